// File: rtl/dht11_receptor.sv
// dht11_receptor
//   Single-wire DHT11 protocol engine. On a one-cycle start request it drives
//   the host start pulse, detects the sensor response, receives the 40-bit
//   frame MSB first, verifies the checksum and reports the outcome.
//
// Ports
//   clock        system clock, all state on the rising edge
//   reset        asynchronous active-high reset (returns to OCIOSO)
//   iniciar      one-cycle start request, ignored while busy
//   dht_in       raw data line level, asynchronous to clock
//   dht_oe       1 = drive the line low (open-drain enable)
//   dados        last received frame, bit 39 is the first bit on the wire
//   fim_recepcao one-cycle pulse at the end of every attempt
//   medida_ok    last attempt completed with a valid checksum
//   erro_timeout one-cycle pulse with fim_recepcao when an attempt times out
//   ocupado      1 in every state except OCIOSO
module dht11_receptor #(
    parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
    parameter int unsigned T_START_US   = 18000,
    parameter int unsigned T_LIBERA_US  = 30,
    parameter int unsigned T_LIMIAR_US  = 50,
    parameter int unsigned T_TIMEOUT_US = 200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar,
    input  logic        dht_in,
    output logic        dht_oe,
    output logic [39:0] dados,
    output logic        fim_recepcao,
    output logic        medida_ok,
    output logic        erro_timeout,
    output logic        ocupado
);

    localparam int unsigned CYC_US      = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned START_CYC   = T_START_US * CYC_US;
    localparam int unsigned LIBERA_CYC  = T_LIBERA_US * CYC_US;
    localparam int unsigned LIMIAR_CYC  = T_LIMIAR_US * CYC_US;
    localparam int unsigned TIMEOUT_CYC = T_TIMEOUT_US * CYC_US;
    localparam int unsigned CW          = $clog2(START_CYC + 1);

    // The counter reads k-1 during the k-th cycle spent in a state, so the
    // "last cycle" compare values are the durations minus one.
    localparam logic [CW-1:0] START_FIM   = CW'(START_CYC - 1);
    localparam logic [CW-1:0] LIBERA_FIM  = CW'(LIBERA_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_FIM = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] LIMIAR      = CW'(LIMIAR_CYC);

    typedef enum logic [2:0] {
        OCIOSO,
        START,
        LIBERA,
        RESP_BAIXO,
        RESP_ALTO,
        BIT_BAIXO,
        BIT_ALTO,
        VERIFICA
    } estado_t;

    estado_t       estado;
    estado_t       estado_prox;
    logic [1:0]    sinc;
    logic          amostra_ant;
    logic          subida;
    logic          descida;
    logic          medindo;
    logic          limpa;
    logic          estourou;
    logic          iniciou;
    logic          captura;
    logic          bit_lido;
    logic [CW-1:0] cnt;
    logic [5:0]    bit_idx;
    logic [39:0]   deslocador;
    logic [7:0]    soma;

    // Edges compare the synchronized sample with the one before it.
    assign subida   = sinc[1] & ~amostra_ant;
    assign descida  = ~sinc[1] & amostra_ant;
    assign estourou = (cnt >= TIMEOUT_FIM);
    assign bit_lido = (cnt > LIMIAR);
    assign medindo  = (estado == RESP_BAIXO) || (estado == RESP_ALTO) ||
                      (estado == BIT_BAIXO)  || (estado == BIT_ALTO);
    assign limpa    = (estado_prox != estado) || (medindo && (subida || descida));
    assign soma     = deslocador[39:32] + deslocador[31:24] +
                      deslocador[23:16] + deslocador[15:8];

    assign dht_oe  = (estado == START);
    assign ocupado = (estado != OCIOSO);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    always_comb begin
        estado_prox  = estado;
        fim_recepcao = 1'b0;
        erro_timeout = 1'b0;
        iniciou      = 1'b0;
        captura      = 1'b0;
        case (estado)
            OCIOSO: begin
                if (iniciar) begin
                    iniciou     = 1'b1;
                    estado_prox = START;
                end
            end
            START: begin
                if (cnt == START_FIM) estado_prox = LIBERA;
            end
            LIBERA: begin
                if (cnt == LIBERA_FIM) estado_prox = RESP_BAIXO;
            end
            RESP_BAIXO: begin
                // A detected rising edge implies the low phase was seen.
                if (subida) estado_prox = RESP_ALTO;
            end
            RESP_ALTO: begin
                if (descida) estado_prox = BIT_BAIXO;
            end
            BIT_BAIXO: begin
                if (subida) estado_prox = BIT_ALTO;
            end
            BIT_ALTO: begin
                if (descida) begin
                    captura     = 1'b1;
                    estado_prox = (bit_idx == 6'd39) ? VERIFICA : BIT_BAIXO;
                end
            end
            VERIFICA: begin
                fim_recepcao = 1'b1;
                estado_prox  = OCIOSO;
            end
            default: estado_prox = OCIOSO;
        endcase

        if (medindo && estourou && (estado_prox == estado)) begin
            fim_recepcao = 1'b1;
            erro_timeout = 1'b1;
            estado_prox  = OCIOSO;
        end
    end

    // Synchronizer idles high (pulled-up line) so reset creates no edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinc        <= 2'b11;
            amostra_ant <= 1'b1;
        end else begin
            sinc        <= {sinc[0], dht_in};
            amostra_ant <= sinc[1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (limpa) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_idx    <= '0;
            deslocador <= '0;
            dados      <= '0;
            medida_ok  <= 1'b0;
        end else begin
            if (iniciou) begin
                bit_idx   <= '0;
                medida_ok <= 1'b0;
            end
            if (captura) begin
                deslocador <= {deslocador[38:0], bit_lido};
                bit_idx    <= bit_idx + 6'd1;
            end
            if (estado == VERIFICA) begin
                dados     <= deslocador;
                medida_ok <= (soma == deslocador[7:0]);
            end
            if (erro_timeout) begin
                medida_ok <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dht11_receptor.sv
// tb_dht11_receptor
//   Directed bench for dht11_receptor at 1 MHz (1 cycle = 1 us). A sensor
//   model answers the start pulse and sends frames with 50 us low phases
//   and 26 us (0) / 70 us (1) high phases.
module tb_dht11_receptor;

    localparam logic [39:0] FRAME_OK  = 40'h3C001A0056;
    localparam logic [39:0] FRAME_BAD = 40'h3C001A0057;
    localparam int          START_LEN = 18000;

    logic        clock;
    logic        reset;
    logic        iniciar;
    logic        dht_in;
    logic        dht_oe;
    logic [39:0] dados;
    logic        fim_recepcao;
    logic        medida_ok;
    logic        erro_timeout;
    logic        ocupado;

    int n_checks = 0;
    int n_pass   = 0;
    int fim_cnt  = 0;

    dht11_receptor #(
        .CLK_FREQ_HZ (1_000_000),
        .T_START_US  (18000),
        .T_LIBERA_US (30),
        .T_LIMIAR_US (50),
        .T_TIMEOUT_US(200)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .dht_in      (dht_in),
        .dht_oe      (dht_oe),
        .dados       (dados),
        .fim_recepcao(fim_recepcao),
        .medida_ok   (medida_ok),
        .erro_timeout(erro_timeout),
        .ocupado     (ocupado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (fim_recepcao === 1'b1) fim_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic hold(input logic v, input int n);
        dht_in = v;
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_iniciar();
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    // Measures the start pulse, then plays the response and nbits data bits.
    // Returns with the line pulled low (end of the last high phase).
    task automatic sensor(input logic [39:0] f, input int nbits, output int oe_len);
        int k;
        k      = 0;
        oe_len = 0;
        while (dht_oe !== 1'b1 && k < 50) begin
            @(negedge clock);
            k++;
        end
        while (dht_oe === 1'b1 && oe_len < 40000) begin
            @(negedge clock);
            oe_len++;
        end
        if (nbits > 0) begin
            hold(1'b1, 20);
            hold(1'b0, 80);
            hold(1'b1, 80);
            for (int i = 0; i < nbits; i++) begin
                hold(1'b0, 50);
                hold(1'b1, f[39-i] ? 70 : 26);
            end
            dht_in = 1'b0;
        end
    endtask

    task automatic wait_fim(input int lim, output int k);
        k = 0;
        while (fim_recepcao !== 1'b1 && k < lim) begin
            @(negedge clock);
            k++;
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({dht_oe, dados, fim_recepcao, medida_ok, erro_timeout, ocupado} !== 45'h0)
            $display("FAIL reset_outputs: got oe=%b dados=%h fim=%b ok=%b err=%b busy=%b, expected all 0",
                     dht_oe, dados, fim_recepcao, medida_ok, erro_timeout, ocupado);
        else n_pass++;
    endtask

    // Good frame, with extra iniciar pulses during START and BIT_ALTO.
    task automatic test_good_frame();
        int oe_len, k, f0;
        f0 = fim_cnt;
        pulse_iniciar();
        fork
            sensor(FRAME_OK, 40, oe_len);
            begin
                repeat (1000) @(negedge clock);
                pulse_iniciar();
                // lands 240 cycles after release: inside the first bit's high phase
                repeat (17239) @(negedge clock);
                pulse_iniciar();
            end
        join
        n_checks++;
        if (oe_len !== START_LEN) $display("FAIL good_oe_len: got %0d expected %0d", oe_len, START_LEN);
        else n_pass++;
        wait_fim(50, k);
        n_checks++;
        if (k >= 50) $display("FAIL good_fim_seen: got no fim within %0d cycles, expected fim", k);
        else n_pass++;
        n_checks++;
        if (erro_timeout !== 1'b0) $display("FAIL good_erro: got %b expected 0", erro_timeout);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (fim_recepcao !== 1'b0) $display("FAIL good_fim_width: got %b expected 0", fim_recepcao);
        else n_pass++;
        n_checks++;
        if (dados !== FRAME_OK) $display("FAIL good_dados: got %h expected %h", dados, FRAME_OK);
        else n_pass++;
        n_checks++;
        if (medida_ok !== 1'b1) $display("FAIL good_medida_ok: got %b expected 1", medida_ok);
        else n_pass++;
        repeat (45) @(negedge clock);
        dht_in = 1'b1;
        repeat (20) @(negedge clock);
        n_checks++;
        if (fim_cnt - f0 !== 1) $display("FAIL good_fim_count: got %0d expected 1", fim_cnt - f0);
        else n_pass++;
        n_checks++;
        if (ocupado !== 1'b0) $display("FAIL good_idle_after: got %b expected 0", ocupado);
        else n_pass++;
    endtask

    task automatic test_partial_frame();
        int oe_len, k, f0;
        f0 = fim_cnt;
        pulse_iniciar();
        sensor(FRAME_OK, 20, oe_len);
        wait_fim(400, k);
        n_checks++;
        if (k >= 400) $display("FAIL partial_fim_seen: got no fim within %0d cycles, expected fim", k);
        else n_pass++;
        n_checks++;
        if (erro_timeout !== 1'b1) $display("FAIL partial_erro: got %b expected 1", erro_timeout);
        else n_pass++;
        n_checks++;
        if (medida_ok !== 1'b0) $display("FAIL partial_medida_ok: got %b expected 0", medida_ok);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (ocupado !== 1'b0) $display("FAIL partial_ocupado_next: got %b expected 0", ocupado);
        else n_pass++;
        n_checks++;
        if (dados !== FRAME_OK) $display("FAIL partial_dados_kept: got %h expected %h", dados, FRAME_OK);
        else n_pass++;
        dht_in = 1'b1;
        repeat (10) @(negedge clock);
        n_checks++;
        if (fim_cnt - f0 !== 1) $display("FAIL partial_fim_count: got %0d expected 1", fim_cnt - f0);
        else n_pass++;
    endtask

    task automatic test_no_response();
        int oe_len, k;
        pulse_iniciar();
        sensor(FRAME_OK, 0, oe_len);
        // 30 cycles in LIBERA after the first released cycle, then 200 in RESP_BAIXO
        wait_fim(400, k);
        n_checks++;
        if (k < 225 || k > 235) $display("FAIL noresp_latency: got %0d cycles expected 225..235", k);
        else n_pass++;
        n_checks++;
        if (erro_timeout !== 1'b1) $display("FAIL noresp_erro: got %b expected 1", erro_timeout);
        else n_pass++;
        n_checks++;
        if (medida_ok !== 1'b0) $display("FAIL noresp_medida_ok: got %b expected 0", medida_ok);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (dados !== FRAME_OK) $display("FAIL noresp_dados_kept: got %h expected %h", dados, FRAME_OK);
        else n_pass++;
    endtask

    task automatic test_reset_mid_start();
        pulse_iniciar();
        repeat (100) @(negedge clock);
        n_checks++;
        if (dht_oe !== 1'b1) $display("FAIL midreset_oe_before: got %b expected 1", dht_oe);
        else n_pass++;
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({dht_oe, dados, fim_recepcao, medida_ok, erro_timeout, ocupado} !== 45'h0)
            $display("FAIL midreset_outputs: got oe=%b dados=%h fim=%b ok=%b err=%b busy=%b, expected all 0",
                     dht_oe, dados, fim_recepcao, medida_ok, erro_timeout, ocupado);
        else n_pass++;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    // Bad checksum after reset, with iniciar raised in the fim cycle.
    task automatic test_bad_checksum();
        int oe_len, k;
        pulse_iniciar();
        sensor(FRAME_BAD, 40, oe_len);
        n_checks++;
        if (oe_len !== START_LEN) $display("FAIL bad_oe_len: got %0d expected %0d", oe_len, START_LEN);
        else n_pass++;
        wait_fim(50, k);
        n_checks++;
        if (k >= 50) $display("FAIL bad_fim_seen: got no fim within %0d cycles, expected fim", k);
        else n_pass++;
        n_checks++;
        if (erro_timeout !== 1'b0) $display("FAIL bad_erro: got %b expected 0", erro_timeout);
        else n_pass++;
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        n_checks++;
        if (dados !== FRAME_BAD) $display("FAIL bad_dados: got %h expected %h", dados, FRAME_BAD);
        else n_pass++;
        n_checks++;
        if (medida_ok !== 1'b0) $display("FAIL bad_medida_ok: got %b expected 0", medida_ok);
        else n_pass++;
        repeat (5) @(negedge clock);
        n_checks++;
        if ({ocupado, dht_oe} !== 2'b00) $display("FAIL bad_iniciar_at_fim: got busy,oe=%b expected 00", {ocupado, dht_oe});
        else n_pass++;
        repeat (40) @(negedge clock);
        dht_in = 1'b1;
        repeat (10) @(negedge clock);
    endtask

    initial begin
        reset   = 1'b1;
        iniciar = 1'b0;
        dht_in  = 1'b1;
        repeat (3) @(negedge clock);
        test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        test_good_frame();
        test_partial_frame();
        test_no_response();
        test_reset_mid_start();
        test_bad_checksum();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dht11_receptor.md
Name: dht11_receptor

Overview:
Single-wire DHT11 protocol engine that sits directly downstream of the DHT11 interface control unit. On a one-cycle start request it drives the host start pulse and detects the sensor response. It then receives the 40-bit frame, verifies the checksum and reports completion back to the control unit via fim_recepcao and medida_ok. The 40-bit frame is exposed for the control unit's storage register.

Parameters:
CLK_FREQ_HZ, 50000000, system clock frequency; all cycle counts derive from it.
T_START_US, 18000, duration the host holds the line low for the start pulse.
T_LIBERA_US, 30, wait after releasing the line before sampling for the sensor response.
T_LIMIAR_US, 50, high-phase duration threshold separating bit 0 from bit 1.
T_TIMEOUT_US, 200, maximum time allowed in any wait-for-edge phase.

Ports:
clock  in  1  system clock; all state on rising edge.
reset  in  1  asynchronous, active-high; returns the block to OCIOSO.
iniciar  in  1  one-cycle start request (the control unit's medir_out).
dht_in  in  1  raw data line level; asynchronous to clock.
dht_oe  out  1  1 = drive the line low (open-drain enable); 0 = released.
dados  out  40  last received frame; bit 39 is the first bit on the wire.
fim_recepcao  out  1  one-cycle pulse marking the end of an attempt, success or failure.
medida_ok  out  1  1 = last attempt completed with a valid checksum; held until the next start.
erro_timeout  out  1  one-cycle pulse, coincident with fim_recepcao, when an attempt aborts on timeout.
ocupado  out  1  1 in every state except OCIOSO.

Behaviour:
- Reset values: dht_oe=0, dados=0, fim_recepcao=0, medida_ok=0, erro_timeout=0, ocupado=0, state=OCIOSO. Reset asserted mid-attempt releases the line immediately (asynchronous).
- dht_in passes through a 2-flop synchronizer. Edge detection compares the synchronized sample with the previous sample, so measured durations carry a fixed 2-3 cycle offset.
- One duration counter, sized to hold the T_START_US cycle count. It clears on every state entry and on every detected edge in measuring states.
- State OCIOSO: waits for iniciar. Then: medida_ok<=0, bit index<=0, go to START.
- State START: dht_oe=1 for T_START_US cycles, then go to LIBERA.
- State LIBERA: dht_oe=0. Wait T_LIBERA_US cycles, then go to RESP_BAIXO.
- State RESP_BAIXO: wait for the line low, then high. On the rising edge go to RESP_ALTO.
- State RESP_ALTO: wait for a falling edge, then go to BIT_BAIXO.
- State BIT_BAIXO: wait for a rising edge, then go to BIT_ALTO.
- State BIT_ALTO: count cycles while the line is high. On the falling edge:
  - Shift in (count > T_LIMIAR_US cycles) ? 1 : 0, MSB first.
  - Increment the bit index.
  - If 40 bits have been received go to VERIFICA, else go to BIT_BAIXO.
- State VERIFICA, one cycle:
  - dados <= shift register.
  - medida_ok <= ((d[39:32]+d[31:24]+d[23:16]+d[15:8]) mod 256 == d[7:0]).
  - fim_recepcao=1, go to OCIOSO.
- Timeout: in RESP_BAIXO, RESP_ALTO, BIT_BAIXO and BIT_ALTO, if the counter reaches T_TIMEOUT_US cycles without the expected edge:
  - fim_recepcao=1, erro_timeout=1, medida_ok=0.
  - dados unchanged; go to OCIOSO.
- The final sensor low pulse after bit 40 is not waited for.
- iniciar while ocupado=1 is ignored. iniciar in the same cycle as fim_recepcao is also ignored (the block is not yet in OCIOSO).
- Retries are the control unit's responsibility. The block never restarts an attempt on its own.

Test Plan:
- Sim with CLK_FREQ_HZ=1000000 (1 cycle = 1 us). Sensor model sends frame 0x3C001A0056 (bits: 50 us low, then 26 us high = 0 / 70 us high = 1):
  - dht_oe high 18000 cycles, then released.
  - fim_recepcao pulses once, dados=0x3C001A0056, medida_ok=1, erro_timeout=0.
- Same frame with checksum byte 0x57 -> fim_recepcao=1, medida_ok=0, dados=0x3C001A0057, erro_timeout=0.
- No sensor response (line held high after release) -> fim_recepcao and erro_timeout pulse together, about 200 cycles after entering RESP_BAIXO; medida_ok=0; dados keeps its previous value.
- Sensor stops after 20 bits -> timeout in BIT_BAIXO; erro_timeout=1; ocupado returns to 0 the next cycle.
- iniciar re-pulsed during START and BIT_ALTO -> no effect on timing. Exactly one fim_recepcao per accepted start.
- reset asserted mid-START -> dht_oe=0 with no clock edge; all outputs at reset values. A subsequent iniciar runs a full frame correctly.
